// File: rtl/if_stage_bp.sv
// Fetch stage with bimodal branch prediction and the IF/ID pipeline register.
// Trains the 2-bit counter table from EX resolution and redirects fetch on mispredict.
module if_stage_bp #(
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter logic [1:0]  INIT_CNT    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        ex_branch_vld,
  input  logic [31:0] ex_pc,
  input  logic        ex_bp,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        BP_ID,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int         IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        bp_id_q, bp_id_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic [1:0]  bht_upd_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_old;
  logic             is_br;
  logic             pred;
  logic [31:0]      br_imm;
  logic [31:0]      pred_target;
  logic [31:0]      redirect_pc;

  assign fetch_idx = pc_q[IDX_W+1:2];
  assign upd_idx   = ex_pc[IDX_W+1:2];
  assign imem_addr = pc_q;

  // Pre-decode and lookup use the registered table, so a same-cycle update is seen only next cycle.
  always_comb begin
    is_br       = (imem_rdata[6:0] == OP_BRANCH);
    br_imm      = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                   imem_rdata[11:8], 1'b0};
    pred_target = pc_q + br_imm;
    pred        = is_br & bht_q[fetch_idx][1];
    flush       = ex_branch_vld & (ex_taken != ex_bp);
    redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  end

  always_comb begin
    pc_d       = pc_q + 32'd4;
    pc_id_d    = pc_q;
    instr_id_d = imem_rdata;
    bp_id_d    = pred;
    if (flush) begin
      pc_d       = redirect_pc;
      pc_id_d    = 32'd0;
      instr_id_d = NOP_INSTR;
      bp_id_d    = 1'b0;
    end else if (stall) begin
      pc_d       = pc_q;
      pc_id_d    = pc_id_q;
      instr_id_d = instr_id_q;
      bp_id_d    = bp_id_q;
    end else if (pred) begin
      pc_d = pred_target;
    end
  end

  always_comb begin
    upd_old   = bht_q[upd_idx];
    bht_upd_d = upd_old;
    if (ex_taken && upd_old != 2'b11) begin
      bht_upd_d = upd_old + 2'd1;
    end else if (!ex_taken && upd_old != 2'b00) begin
      bht_upd_d = upd_old - 2'd1;
    end
    br_cnt_d      = (ex_branch_vld && br_cnt_q != '1) ? br_cnt_q + 32'd1 : br_cnt_q;
    mispred_cnt_d = (flush && mispred_cnt_q != '1) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      pc_id_q       <= 32'd0;
      instr_id_q    <= NOP_INSTR;
      bp_id_q       <= 1'b0;
      br_cnt_q      <= 32'd0;
      mispred_cnt_q <= 32'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= INIT_CNT;
      end
    end else begin
      pc_q          <= pc_d;
      pc_id_q       <= pc_id_d;
      instr_id_q    <= instr_id_d;
      bp_id_q       <= bp_id_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (ex_branch_vld) begin
        bht_q[upd_idx] <= bht_upd_d;
      end
    end
  end

  assign pc_ID       = pc_id_q;
  assign instr_ID    = instr_id_q;
  assign BP_ID       = bp_id_q;
  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_if_stage_bp.sv
// Bench for if_stage_bp: expected fetch/ID states are queued with each stimulus step
// and popped after the clock edge.
module tb_if_stage_bp;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] imem_addr, imem_rdata;
  logic        ex_branch_vld, ex_bp, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        flush;
  logic [31:0] pc_ID, instr_ID;
  logic        BP_ID;
  logic [31:0] br_cnt, mispred_cnt;

  localparam logic [31:0] BEQ_M8 = 32'hFE000CE3;  // beq x0,x0,-8
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_run  = 0;
  int   n_fail = 0;
  int   sb_id  = 0;

  if_stage_bp dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ex_branch_vld(ex_branch_vld), .ex_pc(ex_pc), .ex_bp(ex_bp),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .flush(flush), .pc_ID(pc_ID), .instr_ID(instr_ID), .BP_ID(BP_ID),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h10) return BEQ_M8;
    return {a[15:0], 16'h0013};
  endfunction

  always_comb imem_rdata = instr_at(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] pc,
                      input logic [31:0] instr, input logic bp);
    exp_t x;
    x.id = sb_id; x.addr = addr; x.pc = pc; x.instr = instr; x.bp = bp;
    sb_id++;
    sb.push_back(x);
  endtask

  task automatic set_ex(input logic vld, input logic [31:0] pc, input logic bp,
                        input logic tk, input logic [31:0] tgt);
    ex_branch_vld = vld; ex_pc = pc; ex_bp = bp; ex_taken = tk; ex_target = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    n_run++;
    if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {32'h0, 32'h0, NOP, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want 0 0 00000013 0",
               imem_addr, pc_ID, instr_ID, BP_ID);
    end
    n_run++;
    if ({br_cnt, mispred_cnt} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got br=%h mis=%h want 0 0", br_cnt, mispred_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 3; k++) push(32'(4*k), 32'(4*(k-1)), instr_at(32'(4*(k-1))), 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {e.addr, e.pc, e.instr, e.bp}) begin
        n_fail++;
        $display("FAIL seq#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want %h %h %h %b",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, e.addr, e.pc, e.instr, e.bp);
      end
    end
  endtask

  task automatic test_train();
    logic [1:0] exp_cnt[2];
    exp_cnt[0] = 2'b10; exp_cnt[1] = 2'b11;
    stall = 1'b1;
    set_ex(1'b1, 32'h10, 1'b1, 1'b1, 32'h08);
    #1; n_run++;
    if (flush !== 1'b0) begin
      n_fail++; $display("FAIL train_flush: got %b want 0", flush);
    end
    for (int k = 0; k < 2; k++) begin
      push(32'h0C, 32'h08, instr_at(32'h08), 1'b0);
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {e.addr, e.pc, e.instr, e.bp}) begin
        n_fail++;
        $display("FAIL train_hold#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want %h %h %h %b",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, e.addr, e.pc, e.instr, e.bp);
      end
      n_run++;
      if (dut.bht_q[4] !== exp_cnt[k]) begin
        n_fail++; $display("FAIL train_bht%0d: got %b want %b", k, dut.bht_q[4], exp_cnt[k]);
      end
    end
    n_run++;
    if (br_cnt !== 32'd2) begin
      n_fail++; $display("FAIL train_br_cnt: got %0d want 2", br_cnt);
    end
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stall = 1'b0;
  endtask

  task automatic test_predict();
    push(32'h10, 32'h0C, instr_at(32'h0C), 1'b0);
    push(32'h08, 32'h10, BEQ_M8, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {e.addr, e.pc, e.instr, e.bp}) begin
        n_fail++;
        $display("FAIL predict#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want %h %h %h %b",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, e.addr, e.pc, e.instr, e.bp);
      end
    end
  endtask

  task automatic test_mispredict();
    set_ex(1'b1, 32'h10, 1'b1, 1'b0, 32'h08);
    #1; n_run++;
    if (flush !== 1'b1) begin
      n_fail++; $display("FAIL mispred_flush: got %b want 1", flush);
    end
    push(32'h14, 32'h0, NOP, 1'b0);
    tick(); e = sb.pop_front(); n_run++;
    if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {e.addr, e.pc, e.instr, e.bp}) begin
      n_fail++;
      $display("FAIL mispred_redirect#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want %h %h %h %b",
               e.id, imem_addr, pc_ID, instr_ID, BP_ID, e.addr, e.pc, e.instr, e.bp);
    end
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1; n_run++;
    if (flush !== 1'b0) begin
      n_fail++; $display("FAIL mispred_flush_clear: got %b want 0", flush);
    end
    n_run++;
    if ({mispred_cnt, br_cnt, dut.bht_q[4]} !== {32'd1, 32'd3, 2'b10}) begin
      n_fail++;
      $display("FAIL mispred_state: got mis=%0d br=%0d bht4=%b want 1 3 10",
               mispred_cnt, br_cnt, dut.bht_q[4]);
    end
  endtask

  task automatic test_stall_flush();
    push(32'h18, 32'h14, instr_at(32'h14), 1'b0);
    for (int k = 0; k < 3; k++) push(32'h18, 32'h14, instr_at(32'h14), 1'b0);
    push(32'h100, 32'h0, NOP, 1'b0);
    push(32'h104, 32'h100, instr_at(32'h100), 1'b0);
    for (int k = 0; k < 6; k++) begin
      stall = (k >= 1 && k <= 4);
      if (k == 4) set_ex(1'b1, 32'h40, 1'b0, 1'b1, 32'h100);
      else        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {e.addr, e.pc, e.instr, e.bp}) begin
        n_fail++;
        $display("FAIL stall_flush#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want %h %h %h %b",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, e.addr, e.pc, e.instr, e.bp);
      end
    end
    n_run++;
    if ({mispred_cnt, br_cnt} !== {32'd2, 32'd4}) begin
      n_fail++; $display("FAIL stall_flush_cnt: got mis=%0d br=%0d want 2 4", mispred_cnt, br_cnt);
    end
  endtask

  task automatic test_saturation_alias();
    logic [1:0] exp_cnt[4];
    exp_cnt[0] = 2'b10; exp_cnt[1] = 2'b01; exp_cnt[2] = 2'b00; exp_cnt[3] = 2'b00;
    // taken on 0x110 aliases entry 4: 10 -> 11 -> 11
    stall = 1'b1;
    set_ex(1'b1, 32'h110, 1'b1, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      push(32'h104, 32'h100, instr_at(32'h100), 1'b0);
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID, dut.bht_q[4]} !==
          {e.addr, e.pc, e.instr, e.bp, 2'b11}) begin
        n_fail++;
        $display("FAIL sat_up#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b bht4=%b want %h %h %h %b 11",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, dut.bht_q[4], e.addr, e.pc, e.instr, e.bp);
      end
    end
    // redirect to 0x10, then the lookup there must predict taken
    stall = 1'b0;
    set_ex(1'b1, 32'h200, 1'b0, 1'b1, 32'h10);
    push(32'h10, 32'h0, NOP, 1'b0);
    push(32'h08, 32'h10, BEQ_M8, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {e.addr, e.pc, e.instr, e.bp}) begin
        n_fail++;
        $display("FAIL alias#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want %h %h %h %b",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, e.addr, e.pc, e.instr, e.bp);
      end
      set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    // four not-taken on 0x10 while stalled: 11 -> 10 -> 01 -> 00 -> 00
    stall = 1'b1;
    set_ex(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      push(32'h08, 32'h10, BEQ_M8, 1'b1);
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID, dut.bht_q[4]} !==
          {e.addr, e.pc, e.instr, e.bp, exp_cnt[k]}) begin
        n_fail++;
        $display("FAIL sat_down#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b bht4=%b want %h %h %h %b %b",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, dut.bht_q[4],
                 e.addr, e.pc, e.instr, e.bp, exp_cnt[k]);
      end
    end
    // not-taken resolve of 0x0C predicted taken: redirect to 0x10, now predicted not-taken
    stall = 1'b0;
    set_ex(1'b1, 32'h0C, 1'b1, 1'b0, 32'h0);
    push(32'h10, 32'h0, NOP, 1'b0);
    push(32'h14, 32'h10, BEQ_M8, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick(); e = sb.pop_front(); n_run++;
      if ({imem_addr, pc_ID, instr_ID, BP_ID} !== {e.addr, e.pc, e.instr, e.bp}) begin
        n_fail++;
        $display("FAIL sat_refetch#%0d: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b want %h %h %h %b",
                 e.id, imem_addr, pc_ID, instr_ID, BP_ID, e.addr, e.pc, e.instr, e.bp);
      end
      set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    n_run++;
    if ({br_cnt, mispred_cnt} !== {32'd12, 32'd4}) begin
      n_fail++; $display("FAIL sat_counters: got br=%0d mis=%0d want 12 4", br_cnt, mispred_cnt);
    end
  endtask

  task automatic test_reset_override();
    rst = 1'b1; stall = 1'b1;
    set_ex(1'b1, 32'h10, 1'b0, 1'b1, 32'h80);
    tick();
    n_run++;
    if ({imem_addr, pc_ID, instr_ID, BP_ID, br_cnt, mispred_cnt, dut.bht_q[4]} !==
        {32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0, 2'b01}) begin
      n_fail++;
      $display("FAIL reset_override: got addr=%h pc_ID=%h instr_ID=%h BP_ID=%b br=%0d mis=%0d bht4=%b want 0 0 00000013 0 0 0 01",
               imem_addr, pc_ID, instr_ID, BP_ID, br_cnt, mispred_cnt, dut.bht_q[4]);
    end
    rst = 1'b0; stall = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_train();
    test_predict();
    test_mispredict();
    test_stall_flush();
    test_saturation_alias();
    test_reset_override();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
